// File: rtl/rah_packet_gearbox.sv
// rah_packet_gearbox
//   Packs a stream of IN_WIDTH-bit words into PKT_WIDTH-bit RAH packets,
//   filling from the LSB first. Ready/valid handshakes sit on both sides.
//   A word flagged with in_last starts a drain. Draining blocks input,
//   zero/PAD-pads the tail packet and marks it with out_last.
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   in_data     : input word, bit 0 is the oldest bit
//   in_valid    : in_data present
//   in_last     : current word ends the packet stream (qualified by in_valid)
//   in_ready    : word is accepted this cycle
//   out_data    : packet, bits at/above fill replaced by PAD_BYTE pattern
//   out_valid   : out_data valid
//   out_last    : final packet of a flush
//   out_ready   : consumer takes the packet
//   fill_level  : valid bits currently buffered
//   drop_cnt    : words offered while in_ready was low (saturating)
//   pkt_cnt     : packets popped (wrapping)
//   flush_cnt   : flushes completed (wrapping)
module rah_packet_gearbox #(
  parameter int          IN_WIDTH  = 64,
  parameter int          PKT_WIDTH = 48,
  parameter int          BUF_WORDS = 2,
  parameter logic [7:0]  PAD_BYTE  = 8'h00,
  localparam int         BUF_BITS  = BUF_WORDS * IN_WIDTH + PKT_WIDTH,
  localparam int         FW        = $clog2(BUF_BITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [PKT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [FW-1:0]        fill_level,
  output logic [15:0]          drop_cnt,
  output logic [31:0]          pkt_cnt,
  output logic [15:0]          flush_cnt
);

  localparam logic [FW-1:0] PKT_W    = FW'(PKT_WIDTH);
  localparam logic [FW-1:0] IN_W     = FW'(IN_WIDTH);
  localparam logic [FW-1:0] FILL_MAX = FW'(BUF_BITS - IN_WIDTH);

  logic [BUF_BITS-1:0]  data_q, data_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic                 draining_q, draining_d;
  logic [15:0]          drop_q;
  logic [31:0]          pkt_q;
  logic [15:0]          flush_q;

  logic                 pop, push, flush_done;
  logic [FW-1:0]        popamt, base;
  logic [PKT_WIDTH-1:0] pad_vec, keep_mask;

  // Outputs depend on registered state only, so out_ready never reaches in_ready.
  assign out_valid = (fill_q >= PKT_W) || (draining_q && (fill_q != '0));
  assign out_last  = draining_q && (fill_q != '0) && (fill_q <= PKT_W);
  assign in_ready  = !draining_q && (fill_q <= FILL_MAX);

  // Bits at index fill and above come from the repeated pad byte.
  assign pad_vec   = {(PKT_WIDTH/8){PAD_BYTE}};
  assign keep_mask = (fill_q >= PKT_W) ? {PKT_WIDTH{1'b1}}
                                       : ~({PKT_WIDTH{1'b1}} << fill_q);
  assign out_data  = (data_q[PKT_WIDTH-1:0] & keep_mask) | (pad_vec & ~keep_mask);

  assign fill_level = fill_q;
  assign drop_cnt   = drop_q;
  assign pkt_cnt    = pkt_q;
  assign flush_cnt  = flush_q;

  assign pop  = out_valid && out_ready;
  assign push = in_valid && in_ready;

  // Pop shift first, then the new word lands directly above the survivors.
  // The right shift zero-fills, keeping everything above fill at zero.
  always_comb begin
    popamt = '0;
    if (pop) begin
      popamt = (fill_q < PKT_W) ? fill_q : PKT_W;
    end
    base   = fill_q - popamt;
    data_d = data_q >> popamt;
    fill_d = base;
    if (push) begin
      data_d = data_d | ({{(BUF_BITS-IN_WIDTH){1'b0}}, in_data} << base);
      fill_d = base + IN_W;
    end

    draining_d = draining_q;
    flush_done = 1'b0;
    if (push && in_last) begin
      draining_d = 1'b1;
    end else if (draining_q && (fill_d == '0)) begin
      draining_d = 1'b0;
      flush_done = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      fill_q     <= '0;
      draining_q <= 1'b0;
      drop_q     <= '0;
      pkt_q      <= '0;
      flush_q    <= '0;
    end else begin
      data_q     <= data_d;
      fill_q     <= fill_d;
      draining_q <= draining_d;
      if (in_valid && !in_ready && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
      if (pop) begin
        pkt_q <= pkt_q + 32'd1;
      end
      if (flush_done) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rah_packet_gearbox.sv
module tb_rah_packet_gearbox;

  localparam int         IN_W   = 64;
  localparam int         PKT_W  = 48;
  localparam int         BUF_WD = 2;
  localparam logic [7:0] PAD    = 8'hA5;
  localparam int         BUF_B  = BUF_WD * IN_W + PKT_W;
  localparam int         FW     = $clog2(BUF_B + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [IN_W-1:0]   in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [PKT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready = 1'b0;
  logic [FW-1:0]     fill_level;
  logic [15:0]       drop_cnt;
  logic [31:0]       pkt_cnt;
  logic [15:0]       flush_cnt;

  rah_packet_gearbox #(
    .IN_WIDTH (IN_W),
    .PKT_WIDTH(PKT_W),
    .BUF_WORDS(BUF_WD),
    .PAD_BYTE (PAD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .fill_level(fill_level),
    .drop_cnt  (drop_cnt),
    .pkt_cnt   (pkt_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a plain queue of bits, oldest at index 0.
  bit mq[$];
  bit m_drain;
  int m_drop, m_pkt, m_flush;

  logic [PKT_W-1:0] cap_data[$];
  bit               cap_last[$];

  function automatic bit m_out_valid();
    return (mq.size() >= PKT_W) || (m_drain && mq.size() != 0);
  endfunction

  function automatic bit m_out_last();
    return m_drain && mq.size() != 0 && mq.size() <= PKT_W;
  endfunction

  function automatic bit m_in_ready();
    return !m_drain && (mq.size() <= BUF_B - IN_W);
  endfunction

  function automatic logic [PKT_W-1:0] m_out_data();
    logic [PKT_W-1:0] v;
    for (int i = 0; i < PKT_W; i++) v[i] = (i < mq.size()) ? mq[i] : PAD[i % 8];
    return v;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_drain = 0;
    m_drop = 0;
    m_pkt = 0;
    m_flush = 0;
    cap_data.delete();
    cap_last.delete();
  endtask

  // Called just after a falling edge: compare, drive, advance one clock.
  task automatic step(input bit iv, input bit il, input logic [IN_W-1:0] d, input bit ordy);
    bit ov, ir, pop, push, was_drain;
    int n;
    ov = m_out_valid();
    ir = m_in_ready();
    chk("out_valid", 64'(out_valid), 64'(ov));
    chk("out_last", 64'(out_last), 64'(m_out_last()));
    chk("in_ready", 64'(in_ready), 64'(ir));
    chk("fill_level", 64'(fill_level), 64'(mq.size()));
    chk("out_data", 64'(out_data), 64'(m_out_data()));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    if (ov && ordy) begin
      cap_data.push_back(out_data);
      cap_last.push_back(out_last);
    end
    in_valid  = iv;
    in_last   = il;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    pop = ov && ordy;
    push = iv && ir;
    was_drain = m_drain;
    if (iv && !ir && m_drop < 65535) m_drop++;
    if (pop) begin
      n = (mq.size() < PKT_W) ? mq.size() : PKT_W;
      for (int i = 0; i < n; i++) void'(mq.pop_front());
      m_pkt++;
    end
    if (push) begin
      for (int i = 0; i < IN_W; i++) mq.push_back(d[i]);
      if (il) m_drain = 1;
    end
    if (was_drain && mq.size() == 0) begin
      m_drain = 0;
      m_flush++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, '0, 1);
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic apply_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, ".rst_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".rst_out_last"}, 64'(out_last), 64'd0);
    chk({tag, ".rst_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".rst_fill"}, 64'(fill_level), 64'd0);
    chk({tag, ".rst_out_data"}, 64'(out_data), 64'h0000_A5A5_A5A5_A5A5);
    chk({tag, ".rst_drop"}, 64'(drop_cnt), 64'd0);
    chk({tag, ".rst_pkt"}, 64'(pkt_cnt), 64'd0);
    chk({tag, ".rst_flush"}, 64'(flush_cnt), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, ".rst_hold_last"}, 64'(out_last), 64'd0);
    chk({tag, ".rst_hold_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [IN_W-1:0] w0, w1, w2;
    model_clear();
    @(negedge clk);
    apply_reset("init");
    idle(2);

    // Three words, last on the third: four packets, final one flagged.
    w0 = 64'h0011_2233_4455_6677;
    w1 = 64'h8899_AABB_CCDD_EEFF;
    w2 = 64'hFEDC_BA98_7654_3210;
    step(1, 0, w0, 1);
    step(1, 0, w1, 1);
    step(1, 1, w2, 1);
    idle(4);
    chk("t2.npkt", 64'(cap_data.size()), 64'd4);
    if (cap_data.size() == 4) begin
      chk("t2.p0", 64'(cap_data[0]), 64'h2233_4455_6677);
      chk("t2.p1", 64'(cap_data[1]), 64'hCCDD_EEFF_0011);
      chk("t2.p2", 64'(cap_data[2]), 64'h3210_8899_AABB);
      chk("t2.p3", 64'(cap_data[3]), 64'hFEDC_BA98_7654);
      chk("t2.l2", 64'(cap_last[2]), 64'd0);
      chk("t2.l3", 64'(cap_last[3]), 64'd1);
    end
    chk("t2.flush", 64'(flush_cnt), 64'd1);
    chk("t2.pkt", 64'(pkt_cnt), 64'd4);

    // Single word with last: tail packet padded with A5.
    cap_data.delete();
    cap_last.delete();
    step(1, 1, 64'h0123_4567_89AB_CDEF, 1);
    idle(3);
    chk("t3.npkt", 64'(cap_data.size()), 64'd2);
    if (cap_data.size() == 2) begin
      chk("t3.p0", 64'(cap_data[0]), 64'h4567_89AB_CDEF);
      chk("t3.p1", 64'(cap_data[1]), 64'hA5A5_A5A5_0123);
      chk("t3.l0", 64'(cap_last[0]), 64'd0);
      chk("t3.l1", 64'(cap_last[1]), 64'd1);
    end

    // Reset while draining with 80 bits buffered.
    step(1, 0, 64'h1111_2222_3333_4444, 0);
    step(1, 1, 64'h5555_6666_7777_8888, 1);
    chk("t5.fill80", 64'(fill_level), 64'd80);
    chk("t5.draining", 64'(in_ready), 64'd0);
    apply_reset("t5");
    idle(2);

    // Randomized traffic with backpressure on both sides.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 4) != 0, ($urandom % 12) == 0,
           {$urandom, $urandom}, ($urandom % 3) != 0);
    end
    idle(10);

    // Stalled consumer, continuous input: two words in, the rest dropped.
    apply_reset("t6");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_last   = 1'b0;
    for (int n = 1; n <= 70000; n++) begin
      in_data = {32'(n), ~32'(n)};
      @(posedge clk);
      @(negedge clk);
      if (n == 10) begin
        chk("t4.drop8", 64'(drop_cnt), 64'd8);
        chk("t4.fill128", 64'(fill_level), 64'd128);
        chk("t4.in_ready", 64'(in_ready), 64'd0);
        chk("t4.hold_data", 64'(out_data), 64'h0001_FFFF_FFFE);
        chk("t4.hold_valid", 64'(out_valid), 64'd1);
      end
    end
    chk("t6.drop_sat", 64'(drop_cnt), 64'hFFFF);
    chk("t6.hold_data", 64'(out_data), 64'h0001_FFFF_FFFE);
    chk("t6.pkt", 64'(pkt_cnt), 64'd0);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rah_packet_gearbox.md
# rah_packet_gearbox

Parametrised width converter between the MIPI RX data bus and the RAH decoder. It packs a stream of `IN_WIDTH`-bit words into `PKT_WIDTH`-bit RAH packets, filling from the LSB first. It provides ready/valid backpressure on both sides and a configurable buffer depth. On end-of-packet it zero-pads and flushes any residual bits, and it counts dropped words, packets and flushes. It replaces the fixed 64→48 data aligner between the MIPI RX interface and `rah_decoder`.

## Interface
Parameters:
- `IN_WIDTH`, default 64: input word width in bits. Must be a multiple of 8 and ≥ 8.
- `PKT_WIDTH`, default 48: RAH packet width in bits. Must be a multiple of 8 and ≥ 8.
- `BUF_WORDS`, default 2: input words of slack.
  - Buffer capacity `BUF_BITS` = `BUF_WORDS*IN_WIDTH + PKT_WIDTH`.
  - Fill register width `FW` = `$clog2(BUF_BITS+1)`.
- `PAD_BYTE`, default 8'h00: byte value used for padding on flush.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `in_data`, in, `IN_WIDTH`: input word; bit 0 is the oldest bit.
- `in_valid`, in, 1: `in_data` is present this cycle.
- `in_last`, in, 1: the current word ends the packet stream. Sampled only when `in_valid` is high.
- `in_ready`, out, 1: the block accepts a word this cycle.
- `out_data`, out, `PKT_WIDTH`: packet output.
- `out_valid`, out, 1: `out_data` is valid.
- `out_last`, out, 1: the current packet is the final packet of a flush.
- `out_ready`, in, 1: the consumer takes the packet.
- `fill_level`, out, `FW`: number of valid bits currently in the buffer.
- `drop_cnt`, out, 16: count of words presented with `in_valid=1` while `in_ready=0`. Saturates at 16'hFFFF.
- `pkt_cnt`, out, 32: count of packets popped. Wraps.
- `flush_cnt`, out, 16: count of flushes completed. Wraps.

## Operation
State:
- `buf`: `BUF_BITS` bits.
- `fill`: `FW` bits.
- `draining`: 1 bit.
- The three counters above.

Combinational outputs, derived from registered state only:
- `out_valid` = `fill >= PKT_WIDTH` OR (`draining` AND `fill != 0`).
- `out_data` = `buf[PKT_WIDTH-1:0]`.
  - When `fill < PKT_WIDTH`, bits at index `fill` and above are replaced by `PAD_BYTE`, repeated.
- `out_last` = `draining` AND `fill != 0` AND `fill <= PKT_WIDTH`.
- `in_ready` = NOT `draining` AND `fill <= BUF_BITS - IN_WIDTH`.
- There is no combinational path from `out_ready` to `in_ready`.

Per-cycle update:
- `pop` = `out_valid & out_ready`.
- `push` = `in_valid & in_ready`.
- `popamt` = `pop ? min(fill, PKT_WIDTH) : 0`.
- `base` = `fill - popamt`.
- New `buf` = (`buf >> popamt`) with `in_data` written at bits `[base +: IN_WIDTH]` when `push`.
  - Bits above `base + IN_WIDTH` (or above `base` when there is no push) are zero.
- New `fill` = `base + (push ? IN_WIDTH : 0)`.
- `push & in_last` sets `draining`. Input is then blocked.
- `draining` clears on the cycle `fill` becomes 0.
  - That same cycle, `flush_cnt` increments.
  - `in_ready` reasserts on the following cycle.
- `pkt_cnt` increments on every `pop`, including padded packets.
- `drop_cnt` increments when `in_valid & ~in_ready`. The dropped word never enters `buf`.

Boundary rules:
- Push and pop in the same cycle are both applied; the pop shift happens before the push insertion.
- `fill == BUF_BITS - IN_WIDTH` still accepts a push. Above that value, the word is rejected.
- If `in_last` arrives and the resulting fill is an exact multiple of `PKT_WIDTH`, no pad packet is produced. `out_last` rides on the final full packet.
- `in_last` with `in_valid=0` is ignored.
- `out_valid` holds and `out_data` stays stable while `out_ready=0`.

## Timing
- Reset values:
  - `fill`=0, `buf`=0, `draining`=0, all counters 0.
  - Therefore `out_valid`=0, `out_last`=0, `out_data`=0, `in_ready`=1, `fill_level`=0.
- Latency: a pushed word whose bits complete a packet makes `out_valid` high on the next cycle (1-cycle latency).
- Reset asserted mid-operation clears all state immediately. Buffered bits are discarded and no `out_last` is emitted.
- Throughput: at most one packet out and one word in per cycle.

## Test plan
1. Reset with `in_valid=0` → `in_ready`=1, `out_valid`=0, `fill_level`=0, all counters 0.
2. IN=64, PKT=48, `out_ready`=1. Push W0, W1, W2 back-to-back, `in_last` on W2 → four packets in order:
   - `W0[47:0]`
   - `{W1[31:0], W0[63:48]}`
   - `{W2[15:0], W1[63:32]}`
   - `W2[63:16]` with `out_last`=1
   
   Then `flush_cnt`=1, `pkt_cnt`=4.
3. Push a single word 64'h0123_4567_89AB_CDEF with `in_last` → packets 48'h4567_89AB_CDEF, then 48'h0000_0000_0123 with `out_last`=1. With `PAD_BYTE`=8'hA5, the second packet is 48'hA5A5_A5A5_0123.
4. Hold `out_ready`=0 and drive continuous `in_valid` → exactly 2 words accepted (fill 128 ≤ 112 fails after the second). Every further cycle increments `drop_cnt`, and `out_data` stays stable at W0[47:0].
5. Reset pulse while `draining` with `fill`=80 → all outputs return to reset values on the same edge and no `out_last` is seen.
6. Run 70000 rejected cycles → `drop_cnt` holds at 16'hFFFF.
